// File: rtl/uart_reg_bank_pkg.sv
// Shared definitions for the UART control/status register bank: register map
// indices, the default UART bit patterns and the response pipeline flags.
package uart_reg_bank_pkg;

  localparam int MAP_REGS  = 8;
  localparam int MAP_WIDTH = 32;

  localparam int CTRL     = 0;
  localparam int STATUS   = 1;
  localparam int IRQ_MASK = 2;
  localparam int BAUD_DIV = 3;
  localparam int TX_DATA  = 4;
  localparam int RX_DATA  = 5;

  // Slices are listed from register 7 down to register 0.
  localparam logic [MAP_REGS*MAP_WIDTH-1:0] UART_RW_PATTERN = {
    32'h0, 32'h0, 32'h0, 32'h0000_00FF, 32'h0000_FFFF, 32'h0000_001F, 32'h0, 32'h0000_00FF
  };
  localparam logic [MAP_REGS*MAP_WIDTH-1:0] UART_HW_WR_PATTERN = {
    32'h0, 32'h0, 32'h0000_01FF, 32'h0, 32'h0, 32'h0, 32'h0000_0020, 32'h0
  };
  localparam logic [MAP_REGS*MAP_WIDTH-1:0] UART_RC_PATTERN = {
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_000F, 32'h0
  };
  localparam logic [MAP_REGS*MAP_WIDTH-1:0] UART_W1C_PATTERN = {
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0010, 32'h0
  };
  // Baud divisor defaults to 50 MHz / 115200.
  localparam logic [MAP_REGS*MAP_WIDTH-1:0] UART_RESET_VALUE = {
    32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_01B2, 32'h0, 32'h0, 32'h0
  };

  typedef struct packed {
    logic ack;
    logic err;
  } resp_t;

endpackage

// File: rtl/uart_reg_bank_if.sv
// CPU-side request/acknowledge bus of the UART register bank.
// Handshake: the master raises cpu_req for one cycle per access (every high
// cycle is a new access, never stalled); exactly one cpu_ack pulse follows
// one cycle after the accepting edge, with cpu_err and cpu_rdata valid alongside.
interface uart_reg_bank_if #(
  parameter int ADDR_WIDTH = 3,
  parameter int REG_WIDTH  = 32
);

  logic                  cpu_req;
  logic                  cpu_we;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic [REG_WIDTH-1:0]  cpu_wdata;
  logic [REG_WIDTH-1:0]  cpu_rdata;
  logic                  cpu_ack;
  logic                  cpu_err;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_err
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_err
  );

endinterface

// File: rtl/uart_reg_cell.sv
// One register of the bank with per-bit access types; next state follows the
// priority reset > hw set > cpu write > hw write > cpu read-clear > hold.
module uart_reg_cell #(
  parameter int                WIDTH = 32,
  parameter logic [WIDTH-1:0]  RW    = '0,
  parameter logic [WIDTH-1:0]  HW_WR = '0,
  parameter logic [WIDTH-1:0]  RC    = '0,
  parameter logic [WIDTH-1:0]  W1C   = '0,
  parameter logic [WIDTH-1:0]  RST   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] set,
  input  logic             cpu_wr,
  input  logic             cpu_rd,
  input  logic [WIDTH-1:0] wdata,
  input  logic             hw_wr,
  input  logic [WIDTH-1:0] hw_data,
  output logic [WIDTH-1:0] value
);

  // Bits with no access type never leave their reset value.
  localparam logic [WIDTH-1:0] LIVE = RW | HW_WR | RC | W1C;

  logic [WIDTH-1:0] nxt;

  always_comb begin
    nxt = value;
    if (cpu_wr) begin
      nxt = ((value & ~RW) | (wdata & RW)) & ~(W1C & wdata);
    end else if (hw_wr) begin
      nxt = (value & ~HW_WR) | (hw_data & HW_WR);
    end else if (cpu_rd) begin
      nxt = value & ~RC;
    end
    // Applied last so an event pulse always wins over a same-cycle clear.
    nxt = nxt | set;
    nxt = (nxt & LIVE) | (RST & ~LIVE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RST;
    end else begin
      value <= nxt;
    end
  end

endmodule

// File: rtl/uart_reg_bank.sv
// UART control/status register bank: address decode, CPU handshake and the
// per-register cells. Optional interrupt output enabled by UART_REG_IRQ_EN.
module uart_reg_bank
  import uart_reg_bank_pkg::*;
#(
  parameter int NUM_REGS       = 8,
  parameter int REG_WIDTH      = 32,
  parameter int ADDR_WIDTH     = 3,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RW_PATTERN    = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] HW_WR_PATTERN = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RC_PATTERN    = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] W1C_PATTERN   = '0,
  parameter logic [NUM_REGS*REG_WIDTH-1:0] RESET_VALUE   = '0,
  parameter int IRQ_STATUS_IDX = 0,
  parameter int IRQ_MASK_IDX   = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  uart_reg_bank_if.slave                bus,
  input  logic [NUM_REGS-1:0]           hw_wr_en_i,
  input  logic [NUM_REGS*REG_WIDTH-1:0] hw_data_i,
  input  logic [NUM_REGS*REG_WIDTH-1:0] hw_set_i,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_o,
  output logic                          irq_o
);

  // A misconfigured bank answers every access with an error rather than aliasing.
  localparam bit CFG_OK = ((2 ** ADDR_WIDTH) >= NUM_REGS) &&
                          (IRQ_STATUS_IDX < NUM_REGS) && (IRQ_MASK_IDX < NUM_REGS);

  logic                 in_range;
  logic [REG_WIDTH-1:0] rd_val;
  resp_t                resp_p;
  logic [REG_WIDTH-1:0] rdata_p;

  assign in_range = CFG_OK && (int'(bus.cpu_addr) < NUM_REGS);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic sel;
    assign sel = bus.cpu_req && in_range && (bus.cpu_addr == ADDR_WIDTH'(r));

    uart_reg_cell #(
      .WIDTH (REG_WIDTH),
      .RW    (RW_PATTERN   [r*REG_WIDTH +: REG_WIDTH]),
      .HW_WR (HW_WR_PATTERN[r*REG_WIDTH +: REG_WIDTH]),
      .RC    (RC_PATTERN   [r*REG_WIDTH +: REG_WIDTH]),
      .W1C   (W1C_PATTERN  [r*REG_WIDTH +: REG_WIDTH]),
      .RST   (RESET_VALUE  [r*REG_WIDTH +: REG_WIDTH])
    ) u_cell (
      .clk     (clk_i),
      .rst     (rst_i),
      .set     (hw_set_i[r*REG_WIDTH +: REG_WIDTH]),
      .cpu_wr  (sel && bus.cpu_we),
      .cpu_rd  (sel && !bus.cpu_we),
      .wdata   (bus.cpu_wdata),
      .hw_wr   (hw_wr_en_i[r]),
      .hw_data (hw_data_i[r*REG_WIDTH +: REG_WIDTH]),
      .value   (regs_o[r*REG_WIDTH +: REG_WIDTH])
    );
  end

  // Read mux sees the flop contents, i.e. the value before this edge's update.
  always_comb begin
    rd_val = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (bus.cpu_addr == ADDR_WIDTH'(r)) begin
        rd_val = regs_o[r*REG_WIDTH +: REG_WIDTH];
      end
    end
  end

  // Two stages: capture at the accepting edge, present ack on the next one.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_p        <= '0;
      rdata_p       <= '0;
      bus.cpu_ack   <= 1'b0;
      bus.cpu_err   <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      resp_p.ack  <= bus.cpu_req;
      resp_p.err  <= bus.cpu_req && !in_range;
      rdata_p     <= (bus.cpu_req && !bus.cpu_we && in_range) ? rd_val : '0;
      bus.cpu_ack <= resp_p.ack;
      bus.cpu_err <= resp_p.err;
      if (resp_p.ack) begin
        bus.cpu_rdata <= rdata_p;
      end
    end
  end

`ifdef UART_REG_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(regs_o[IRQ_STATUS_IDX*REG_WIDTH +: REG_WIDTH] &
                 regs_o[IRQ_MASK_IDX*REG_WIDTH +: REG_WIDTH]);
    end
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_reg_bank.sv
// Directed bench for uart_reg_bank: six registers with mixed access types,
// hand-computed expectations; the interrupt section depends on UART_REG_IRQ_EN.
module tb_uart_reg_bank;

  localparam int NR = 6;
  localparam int W  = 32;
  localparam int AW = 3;

  localparam logic [NR*W-1:0] RW_P  = {32'h0, 32'h0000_00FF, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF};
  localparam logic [NR*W-1:0] HW_P  = {32'h0, 32'h0000_00FF, 32'h0000_FFFF, 32'h0, 32'h0, 32'h0};
  localparam logic [NR*W-1:0] RC_P  = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_000F, 32'h0};
  localparam logic [NR*W-1:0] W1C_P = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0010, 32'h0};
  localparam logic [NR*W-1:0] RST_P = {32'h0, 32'h0, 32'h0, 32'h0000_00A5, 32'h0, 32'h0};

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NR-1:0]   hw_wr_en_i;
  logic [NR*W-1:0] hw_data_i;
  logic [NR*W-1:0] hw_set_i;
  logic [NR*W-1:0] regs_o;
  logic            irq_o;

  int n_checks = 0;
  int n_pass   = 0;

  uart_reg_bank_if #(.ADDR_WIDTH(AW), .REG_WIDTH(W)) bus ();

  uart_reg_bank #(
    .NUM_REGS       (NR),
    .REG_WIDTH      (W),
    .ADDR_WIDTH     (AW),
    .RW_PATTERN     (RW_P),
    .HW_WR_PATTERN  (HW_P),
    .RC_PATTERN     (RC_P),
    .W1C_PATTERN    (W1C_P),
    .RESET_VALUE    (RST_P),
    .IRQ_STATUS_IDX (1),
    .IRQ_MASK_IDX   (0)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .bus        (bus.slave),
    .hw_wr_en_i (hw_wr_en_i),
    .hw_data_i  (hw_data_i),
    .hw_set_i   (hw_set_i),
    .regs_o     (regs_o),
    .irq_o      (irq_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] reg_of(input int r);
    return regs_o[r*W +: W];
  endfunction

  function automatic logic [NR*W-1:0] at(input int r, input logic [W-1:0] v);
    logic [NR*W-1:0] vec;
    vec = '0;
    vec[r*W +: W] = v;
    return vec;
  endfunction

  // driver tasks
  task automatic pulse_set(input logic [NR*W-1:0] vec);
    hw_set_i = vec;
    tick();
    hw_set_i = '0;
  endtask

  task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [W-1:0] wdata,
                        input logic [NR*W-1:0] set_vec,
                        output logic [W-1:0] rdata, output logic err, output logic ack);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
    hw_set_i      = set_vec;
    tick();
    bus.cpu_req = 1'b0;
    hw_set_i    = '0;
    check("ack_not_early", {31'b0, bus.cpu_ack}, 32'h0);
    tick();
    rdata = bus.cpu_rdata;
    err   = bus.cpu_err;
    ack   = bus.cpu_ack;
  endtask

  logic [W-1:0] rd;
  logic         er;
  logic         ak;
  logic [W-1:0] exp_r [NR];

  initial begin
    rst_i         = 1'b1;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    hw_wr_en_i    = '0;
    hw_data_i     = '0;
    hw_set_i      = '0;
    tick();
    tick();
    rst_i = 1'b0;

    check("rst_reg2", reg_of(2), 32'h0000_00A5);
    check("rst_reg0", reg_of(0), 32'h0);
    check("rst_ack", {31'b0, bus.cpu_ack}, 32'h0);
    check("rst_rdata", bus.cpu_rdata, 32'h0);
    check("rst_irq", {31'b0, irq_o}, 32'h0);

    // RW register including the MSB
    cpu_op(1'b1, 3'd0, 32'h8000_0001, '0, rd, er, ak);
    check("wr0_ack", {31'b0, ak}, 32'h1);
    check("wr0_err", {31'b0, er}, 32'h0);
    check("wr0_rdata", rd, 32'h0);
    check("wr0_reg", reg_of(0), 32'h8000_0001);
    tick();
    check("ack_one_cycle", {31'b0, bus.cpu_ack}, 32'h0);
    cpu_op(1'b0, 3'd0, 32'h0, '0, rd, er, ak);
    check("rd0_ack", {31'b0, ak}, 32'h1);
    check("rd0_rdata", rd, 32'h8000_0001);

    // read-to-clear
    pulse_set(at(1, 32'h3));
    check("set_reg1", reg_of(1), 32'h3);
    cpu_op(1'b0, 3'd1, 32'h0, '0, rd, er, ak);
    check("rc_rdata", rd, 32'h3);
    check("rc_cleared", reg_of(1), 32'h0);
    pulse_set(at(1, 32'h3));
    cpu_op(1'b0, 3'd1, 32'h0, at(1, 32'h1), rd, er, ak);
    check("rc_set_rdata", rd, 32'h3);
    check("rc_set_wins", reg_of(1), 32'h1);

    // write-1-to-clear
    pulse_set(at(1, 32'h10));
    check("w1c_set", reg_of(1), 32'h11);
    cpu_op(1'b1, 3'd1, 32'h10, '0, rd, er, ak);
    check("w1c_clear", reg_of(1), 32'h1);
    pulse_set(at(1, 32'h10));
    cpu_op(1'b1, 3'd1, 32'h0, '0, rd, er, ak);
    check("w1c_zero_hold", reg_of(1), 32'h11);
    cpu_op(1'b1, 3'd1, 32'h10, at(1, 32'h10), rd, er, ak);
    check("w1c_set_wins", reg_of(1), 32'h11);

    // peripheral write, masked by HW_WR pattern
    hw_wr_en_i = 6'b001000;
    hw_data_i  = at(3, 32'h1234_5678);
    tick();
    hw_wr_en_i = '0;
    check("hw_wr_reg3", reg_of(3), 32'h0000_5678);

    // cpu write outranks a same-cycle peripheral write
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 3'd4;
    bus.cpu_wdata = 32'h11;
    hw_wr_en_i    = 6'b010000;
    hw_data_i     = at(4, 32'h22);
    tick();
    bus.cpu_req = 1'b0;
    check("cpu_over_hw", reg_of(4), 32'h11);
    tick();
    hw_wr_en_i = '0;
    check("hw_after_cpu", reg_of(4), 32'h22);
    tick();

    // register with no access pattern
    cpu_op(1'b1, 3'd2, 32'hFFFF_FFFF, '0, rd, er, ak);
    check("const_reg2", reg_of(2), 32'h0000_00A5);
    cpu_op(1'b0, 3'd2, 32'h0, '0, rd, er, ak);
    check("const_rd2", rd, 32'h0000_00A5);

    // out-of-range accesses
    exp_r = '{32'h8000_0001, 32'h11, 32'hA5, 32'h5678, 32'h22, 32'h0};
    cpu_op(1'b0, 3'd7, 32'h0, '0, rd, er, ak);
    check("oor_rd_ack", {31'b0, ak}, 32'h1);
    check("oor_rd_err", {31'b0, er}, 32'h1);
    check("oor_rd_rdata", rd, 32'h0);
    cpu_op(1'b1, 3'd6, 32'hFFFF_FFFF, '0, rd, er, ak);
    check("oor_wr_err", {31'b0, er}, 32'h1);
    check("oor_wr_rdata", rd, 32'h0);
    for (int r = 0; r < NR; r++) begin
      check($sformatf("oor_hold_reg%0d", r), reg_of(r), exp_r[r]);
    end

    // back-to-back reads
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 3'd0;
    tick();
    bus.cpu_addr = 3'd1;
    tick();
    check("b2b_ack0", {31'b0, bus.cpu_ack}, 32'h1);
    check("b2b_data0", bus.cpu_rdata, 32'h8000_0001);
    bus.cpu_req = 1'b0;
    tick();
    check("b2b_ack1", {31'b0, bus.cpu_ack}, 32'h1);
    check("b2b_err1", {31'b0, bus.cpu_err}, 32'h0);
    check("b2b_data1", bus.cpu_rdata, 32'h11);
    tick();
    check("b2b_ack_end", {31'b0, bus.cpu_ack}, 32'h0);
    check("rdata_held", bus.cpu_rdata, 32'h11);
    check("b2b_rc", reg_of(1), 32'h10);

    // access coinciding with reset is dropped
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 3'd0;
    rst_i        = 1'b1;
    tick();
    rst_i       = 1'b0;
    bus.cpu_req = 1'b0;
    tick();
    check("rst_drop_ack", {31'b0, bus.cpu_ack}, 32'h0);
    check("rst_reload0", reg_of(0), 32'h0);
    check("rst_reload2", reg_of(2), 32'h0000_00A5);

`ifdef UART_REG_IRQ_EN
    cpu_op(1'b1, 3'd0, 32'h2, '0, rd, er, ak);
    pulse_set(at(1, 32'h2));
    check("irq_lag", {31'b0, irq_o}, 32'h0);
    tick();
    check("irq_set", {31'b0, irq_o}, 32'h1);
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 3'd1;
    tick();
    bus.cpu_req = 1'b0;
    check("irq_hold", {31'b0, irq_o}, 32'h1);
    check("irq_status_rc", reg_of(1), 32'h0);
    tick();
    check("irq_clear", {31'b0, irq_o}, 32'h0);
    check("irq_rd_status", bus.cpu_rdata, 32'h2);
`else
    pulse_set(at(1, 32'h2));
    tick();
    check("irq_tied_low", {31'b0, irq_o}, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
